// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch queue with single-outstanding memory fetch
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_addr,
  input  logic                      mem_ack,
  input  logic [XLEN-1:0]           mem_rdata,
  input  logic                      redirect,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_instr,
  output logic [XLEN-1:0]           out_pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] buf_pc_q    [DEPTH];
  logic [XLEN-1:0] buf_pc_d    [DEPTH];
  logic [XLEN-1:0] buf_instr_q [DEPTH];
  logic [XLEN-1:0] buf_instr_d [DEPTH];

  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] next_addr;
  logic [CW-1:0]   count_after;

  assign mem_req   = (state_q == REQ) || (state_q == DROP);
  assign mem_addr  = addr_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = buf_pc_q[rd_ptr_q];
  assign out_instr = buf_instr_q[rd_ptr_q];

  // Redirect targets are forced word-aligned; next sequential address wraps modulo 2^XLEN.
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign next_addr       = addr_q + XLEN'(4);
  assign pop             = out_valid && out_ready && !redirect;
  assign push            = (state_q == REQ) && mem_ack && !redirect;
  assign count_after     = count_q + CW'(push) - CW'(pop);

  // Fetch FSM: issue, back-to-back refill, and draining of a request orphaned by redirect.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d = redirect_target;
        end else if (count_q < CW'(DEPTH)) begin
          addr_d  = fpc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_d   = redirect_target;
          state_d = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          fpc_d = next_addr;
          if (count_after < CW'(DEPTH)) begin
            addr_d = next_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_d = redirect_target;
        end
        // The request issued before the redirect must complete before a new one goes out.
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer occupancy, pointers and entry storage; redirect empties the queue.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]    = addr_q;
        buf_instr_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_after;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      addr_q      <= addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  logic        reset2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic [2:0]  count2;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory model: the returned word is a fixed function of the address.
  assign mem_rdata = mem_addr ^ KEY;

  instr_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  instr_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(one), .mem_rdata(mem_addr2), .redirect(zero),
    .redirect_pc(zero32), .out_valid(out_valid2), .out_ready(one),
    .out_instr(out_instr2), .out_pc(out_pc2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    mem_ack = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'b0, mem_req},   32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", {29'b0, count},     32'd0);
    check("rst_addr",  mem_addr,           32'h0);
    reset = 1'b0; reset2 = 1'b0;

    // Free-running stream; stray ack during IDLE after reset is ignored.
    step();
    check("s1_req",  {31'b0, mem_req}, 32'd1);
    check("s1_addr", mem_addr,         32'h0);
    check("s1_cnt",  {29'b0, count},   32'd0);
    check("wrap0",   mem_addr2,        32'hFFFF_FFF8);
    for (int k = 2; k <= 6; k++) begin
      step();
      check("s_pc",    out_pc,         32'(4 * (k - 2)));
      check("s_instr", out_instr,      32'(4 * (k - 2)) ^ KEY);
      check("s_addr",  mem_addr,       32'(4 * (k - 1)));
      check("s_cnt",   {29'b0, count}, 32'd1);
      if (k == 2) check("wrap1", mem_addr2, 32'hFFFF_FFFC);
      if (k == 3) check("wrap2", mem_addr2, 32'h0000_0000);
    end

    // Fill to DEPTH with consumer stalled, then one pop restarts fetch at 0x10.
    out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    check("full_cnt", {29'b0, count},   32'd4);
    check("full_req", {31'b0, mem_req}, 32'd0);
    step();
    check("full_idle", {31'b0, mem_req}, 32'd0);
    check("full_head", out_pc,           32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_cnt",  {29'b0, count}, 32'd3);
    check("pop_head", out_pc,         32'h4);
    step();
    check("refetch_req",  {31'b0, mem_req}, 32'd1);
    check("refetch_addr", mem_addr,         32'h10);

    // Redirect while a request waits on memory: old request drained and discarded.
    mem_ack = 1'b0; out_ready = 1'b1;
    do_reset();
    step();
    check("d_addr0", mem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    check("drop_req",  {31'b0, mem_req}, 32'd1);
    check("drop_addr", mem_addr,         32'h0);
    step();
    check("drop_hold", mem_addr, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("drop_done_req", {31'b0, mem_req}, 32'd0);
    check("drop_done_cnt", {29'b0, count},   32'd0);
    step();
    check("tgt_addr", mem_addr,         32'h100);
    check("tgt_req",  {31'b0, mem_req}, 32'd1);
    check("tgt_cnt",  {29'b0, count},   32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("tgt_pc",    out_pc,         32'h100);
    check("tgt_instr", out_instr,      32'h100 ^ KEY);
    check("tgt_cnt1",  {29'b0, count}, 32'd1);

    // Redirect coincident with ack and ready: no push, no pop, queue emptied.
    mem_ack = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; mem_ack = 1'b0;
    check("co_cnt",   {29'b0, count},     32'd0);
    check("co_valid", {31'b0, out_valid}, 32'd0);
    check("co_req",   {31'b0, mem_req},   32'd0);
    step();
    check("co_addr", mem_addr,         32'h200);
    check("co_req2", {31'b0, mem_req}, 32'd1);

    // Asynchronous reset mid-REQ with three entries buffered.
    mem_ack = 1'b1; out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    check("pre_cnt", {29'b0, count},   32'd3);
    check("pre_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("ar_req",   {31'b0, mem_req},   32'd0);
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_cnt",   {29'b0, count},     32'd0);
    check("ar_addr",  mem_addr,           32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("ar_refetch_req",  {31'b0, mem_req}, 32'd1);
    check("ar_refetch_addr", mem_addr,         32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
